// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_FRAME   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned CLKS_PER_BIT_DEF = 5208;

endpackage

// File: rtl/uart_rx_byte.sv
// Single 8N1 byte receiver: input synchronizer, byte FSM and bit timer.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] byte_data,
  output logic       byte_valid_c,
  output logic       byte_ferr_c,
  output logic       start_c,
  output logic       idle_c
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  logic          meta_q, sync_q, prev_q;
  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      meta_q  <= rx_serial;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_c = 1'b0;
    byte_ferr_c  = 1'b0;
    start_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        bit_d = '0;
        if (prev_q && !sync_q) begin
          start_c = 1'b1;
          state_d = START;
        end
      end
      // Half-bit check rejects short low glitches without flagging an error.
      START: begin
        if (tmr_q == T_HALF) begin
          tmr_d   = '0;
          state_d = sync_q ? IDLE : DATA;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      DATA: begin
        if (tmr_q == T_FULL) begin
          tmr_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      STOP: begin
        if (tmr_q == T_FULL) begin
          tmr_d = '0;
          if (sync_q) begin
            byte_valid_c = 1'b1;
            state_d      = IDLE;
          end else begin
            byte_ferr_c = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      WAIT_HIGH: begin
        if (sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data = shift_q;
  assign idle_c    = (state_q == IDLE);

endmodule

// File: rtl/uart_frame_rx.sv
// Assembles N_BYTES received UART bytes into one frame with framing and
// inter-byte timeout error reporting.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned N_BYTES      = 2,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           rx_serial,
  output logic [8*N_BYTES-1:0]           frame_data,
  output logic                           frame_valid,
  output logic                           frame_error,
  output logic [1:0]                     error_code,
  output logic                           busy,
  output logic [$clog2(N_BYTES+1)-1:0]   byte_count
);

  localparam int unsigned FW       = 8 * N_BYTES;
  localparam int unsigned CW       = $clog2(N_BYTES + 1);
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned IW       = $clog2(TO_LIMIT + 1);

  logic [7:0] byte_data;
  logic       byte_valid_c, byte_ferr_c, start_c, idle_c;

  logic [FW-1:0] lanes_q, lanes_d;
  logic [FW-1:0] frame_data_q, frame_data_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_error_q, frame_error_d;
  logic [1:0]    error_code_q, error_code_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] byte_count_q, byte_count_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
    .clock        (clock),
    .reset        (reset),
    .rx_serial    (rx_serial),
    .byte_data    (byte_data),
    .byte_valid_c (byte_valid_c),
    .byte_ferr_c  (byte_ferr_c),
    .start_c      (start_c),
    .idle_c       (idle_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lanes_q       <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      error_code_q  <= ERR_NONE;
      busy_q        <= 1'b0;
      byte_count_q  <= '0;
      idle_cnt_q    <= '0;
    end else begin
      lanes_q       <= lanes_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      error_code_q  <= error_code_d;
      busy_q        <= busy_d;
      byte_count_q  <= byte_count_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  // Idle counter runs only while a partial frame waits in IDLE; a start edge wins over expiry.
  always_comb begin
    lanes_d       = lanes_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    error_code_d  = error_code_q;
    byte_count_d  = byte_count_q;
    idle_cnt_d    = '0;
    if (byte_valid_c) begin
      for (int k = 0; k < N_BYTES; k++) begin
        if (byte_count_q == CW'(k)) lanes_d[8*k +: 8] = byte_data;
      end
      if (byte_count_q == CW'(N_BYTES - 1)) begin
        frame_data_d  = lanes_d;
        frame_valid_d = 1'b1;
        byte_count_d  = '0;
      end else begin
        byte_count_d = byte_count_q + CW'(1);
      end
    end else if (byte_ferr_c) begin
      frame_error_d = 1'b1;
      error_code_d  = ERR_FRAME;
      byte_count_d  = '0;
    end else if (idle_c && !start_c && (byte_count_q != '0)) begin
      if (idle_cnt_q == IW'(TO_LIMIT - 1)) begin
        frame_error_d = 1'b1;
        error_code_d  = ERR_TIMEOUT;
        byte_count_d  = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + IW'(1);
      end
    end
    busy_d = !idle_c || (byte_count_d != '0);
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign error_code  = error_code_q;
  assign busy        = busy_q;
  assign byte_count  = byte_count_q;

endmodule
